lcd_bus_arbiter: RTL and testbench
==================================

LCD_BUS_ARBITER -- requirements
Module: lcd_bus_arbiter

Interface
REQ-001 Parameter T_POWERUP, default 2000000: cycles held idle after reset before the first grant (40 ms at 50 MHz).
REQ-002 Parameter T_SETUP, default 2: cycles that lcd_rs and lcd_data are stable before lcd_en rises.
REQ-003 Parameter T_EN_HIGH, default 25: cycles lcd_en stays high.
REQ-004 Parameter T_EXEC, default 2000: post-strobe wait cycles for normal commands and data.
REQ-005 Parameter T_EXEC_LONG, default 82000: post-strobe wait cycles for long commands.
REQ-006 clk  input  1  system clock; all logic is on the rising edge.
REQ-007 reset  input  1  synchronous, active-low reset.
REQ-008 req  input  2  per-requester write request; bit i belongs to requester i.
REQ-009 rs0, rs1  input  1 each  register select from requester 0 and requester 1.
REQ-010 data0, data1  input  8 each  byte from requester 0 and requester 1.
REQ-011 ack  output  2  one-cycle completion pulse to the granted requester.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 lcd_rs, lcd_rw, lcd_en  output  1 each  LCD control pins.
REQ-014 lcd_data  output  8  LCD data bus.

Function
REQ-015 The FSM SHALL use these states: POWERUP, IDLE, SETUP, STROBE, EXEC, DONE.
REQ-016 POWERUP SHALL count T_POWERUP cycles and then go to IDLE; req is ignored during POWERUP.
REQ-017 In IDLE, when any req bit is 1 at a rising edge, the FSM SHALL do all of the following at that edge: latch the winner index, load lcd_rs and lcd_data from the winner's rs/data, and enter SETUP.
REQ-018 SETUP SHALL last T_SETUP cycles with lcd_en=0; STROBE SHALL then last T_EN_HIGH cycles with lcd_en=1.
REQ-019 EXEC SHALL last T_EXEC_LONG cycles when the latched byte is a long command, otherwise T_EXEC cycles; lcd_en=0 throughout.
REQ-020 A long command SHALL be defined as lcd_rs=0 with lcd_data equal to 0x01, 0x02 or 0x03.
REQ-021 DONE SHALL last exactly one cycle with ack[winner]=1 and all other ack bits 0, then return to IDLE.
REQ-022 req SHALL NOT be sampled in DONE, which guarantees at least one non-granting cycle between transactions.
REQ-023 lcd_rs and lcd_data SHALL hold their latched values from SETUP through DONE.
REQ-024 lcd_rw SHALL be constant 0 (write-only).
REQ-025 Requesters SHALL hold req, rs and data stable until they see ack; a req deasserted before ack does not abort a transaction already granted.
REQ-026 Arbitration policy SHALL be as specified in REQ-031/REQ-032.
REQ-027 All delay counters SHALL be sized with $clog2 of the largest parameter and SHALL NOT wrap within a state.

Reset
REQ-028 While reset=0 at a rising edge, the block SHALL enter POWERUP with counters cleared, ack=0, lcd_en=0, lcd_rs=0, lcd_rw=0, lcd_data=0x00, busy=1 and the round-robin pointer set to 1.
REQ-029 A reset that arrives mid-transaction (including during STROBE) SHALL drop lcd_en on the next edge; no ack is issued for the aborted write, and the full T_POWERUP delay restarts.

Configuration
REQ-030 The macro LCD_ARB_ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-031 With LCD_ARB_ROUND_ROBIN_EN defined, when both req bits are set the grant SHALL go to the requester not granted last; the pointer updates on each grant, and a single requester always wins.
REQ-032 Without LCD_ARB_ROUND_ROBIN_EN, requester 0 SHALL have fixed priority over requester 1.

Verification (T_POWERUP=10, T_SETUP=2, T_EN_HIGH=3, T_EXEC=5, T_EXEC_LONG=20)
REQ-033 Reset, then req=01 with rs0=1, data0=0x41 held from cycle 0 -> busy stays 1 with lcd_en=0 for 10 cycles; lcd_data=0x41 and lcd_rs=1; lcd_en high for exactly 3 cycles after 2 setup cycles; ack=01 for one cycle 5 cycles after lcd_en falls.
REQ-034 rs0=0, data0=0x01 -> EXEC lasts 20 cycles; rs0=1, data0=0x01 -> EXEC lasts 5 cycles; rs0=0, data0=0x38 -> EXEC lasts 5 cycles.
REQ-035 req=11 held continuously with LCD_ARB_ROUND_ROBIN_EN defined -> acks alternate 01,10,01,10; without the macro -> four consecutive acks of 01.
REQ-036 reset=0 asserted during the second STROBE cycle -> lcd_en=0 on the next edge; ack stays 00 and POWERUP restarts; after 10 cycles a held req is granted again.
REQ-037 req1 asserts in the same cycle that ack[0] is high -> no grant in that cycle; req1 is granted on the following IDLE edge, and lcd_data switches to data1 there.

Source files
------------

// File: rtl/lcd_bus_arbiter.sv
// Two-requester write arbiter for an HD44780-style character LCD: power-up hold, setup/strobe/exec timing.
// Define LCD_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module lcd_bus_arbiter #(
  parameter int unsigned T_POWERUP   = 2000000,
  parameter int unsigned T_SETUP     = 2,
  parameter int unsigned T_EN_HIGH   = 25,
  parameter int unsigned T_EXEC      = 2000,
  parameter int unsigned T_EXEC_LONG = 82000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       rs0,
  input  logic       rs1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  output logic [1:0] ack,
  output logic       busy,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic [7:0] lcd_data
);

  localparam int unsigned MAX_A = (T_POWERUP > T_EXEC_LONG) ? T_POWERUP : T_EXEC_LONG;
  localparam int unsigned MAX_B = (T_EXEC > T_EN_HIGH) ? T_EXEC : T_EN_HIGH;
  localparam int unsigned MAX_C = (MAX_B > T_SETUP) ? MAX_B : T_SETUP;
  localparam int unsigned T_MAX = (MAX_A > MAX_C) ? MAX_A : MAX_C;
  localparam int unsigned CNT_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  typedef enum logic [2:0] {
    POWERUP = 3'd0,
    IDLE    = 3'd1,
    SETUP   = 3'd2,
    STROBE  = 3'd3,
    EXEC    = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               winner_q, winner_d;
  logic               rs_d;
  logic [7:0]         data_d;
  logic [1:0]         ack_d;
  logic               grant_c;
  logic               long_c;
  logic [CNT_W-1:0]   exec_last_c;

  assign lcd_rw = 1'b0;

  // Clear-display and return-home style commands need the long execution wait.
  assign long_c      = !lcd_rs && (lcd_data inside {8'h01, 8'h02, 8'h03});
  assign exec_last_c = long_c ? CNT_W'(T_EXEC_LONG - 1) : CNT_W'(T_EXEC - 1);

`ifdef LCD_ARB_ROUND_ROBIN_EN
  logic last_q;

  // Pointer holds the last granted requester; contention goes to the other one.
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_q <= 1'b1;
    end else if (state_q == IDLE && |req) begin
      last_q <= grant_c;
    end
  end

  assign grant_c = (&req) ? ~last_q : ~req[0];
`else
  assign grant_c = ~req[0];
`endif

  // Next-state, counter and latch logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    winner_d = winner_q;
    rs_d     = lcd_rs;
    data_d   = lcd_data;
    ack_d    = 2'b00;
    case (state_q)
      POWERUP: begin
        if (cnt_q == CNT_W'(T_POWERUP - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      IDLE: begin
        cnt_d = '0;
        if (|req) begin
          state_d  = SETUP;
          winner_d = grant_c;
          rs_d     = grant_c ? rs1 : rs0;
          data_d   = grant_c ? data1 : data0;
        end
      end
      SETUP: begin
        if (cnt_q == CNT_W'(T_SETUP - 1)) begin
          state_d = STROBE;
          cnt_d   = '0;
        end
      end
      STROBE: begin
        if (cnt_q == CNT_W'(T_EN_HIGH - 1)) begin
          state_d = EXEC;
          cnt_d   = '0;
        end
      end
      EXEC: begin
        if (cnt_q == exec_last_c) begin
          state_d         = DONE;
          cnt_d           = '0;
          ack_d[winner_q] = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = POWERUP;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= POWERUP;
      cnt_q    <= '0;
      winner_q <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_data <= 8'h00;
      lcd_en   <= 1'b0;
      ack      <= 2'b00;
      busy     <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      winner_q <= winner_d;
      lcd_rs   <= rs_d;
      lcd_data <= data_d;
      lcd_en   <= (state_d == STROBE);
      ack      <= ack_d;
      busy     <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Self-checking bench for lcd_bus_arbiter: directed scenarios plus random two-requester traffic
// checked cycle by cycle against a transaction-level model of the arbiter's timing and policy.
module tb_lcd_bus_arbiter;

  localparam int TP  = 10;
  localparam int TS  = 2;
  localparam int TE  = 3;
  localparam int TX  = 5;
  localparam int TXL = 20;

  logic       clk;
  logic       reset;
  logic [1:0] req;
  logic       rs0, rs1;
  logic [7:0] data0, data1;
  logic [1:0] ack;
  logic       busy;
  logic       lcd_rs, lcd_rw, lcd_en;
  logic [7:0] lcd_data;

  int total = 0;
  int bad   = 0;

  // Requester-side model: outstanding request and its payload, plus who was granted last.
  bit       pend [2];
  bit       prs  [2];
  bit [7:0] pdat [2];
  int       last_w;

  lcd_bus_arbiter #(
    .T_POWERUP(TP), .T_SETUP(TS), .T_EN_HIGH(TE), .T_EXEC(TX), .T_EXEC_LONG(TXL)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .rs0(rs0), .rs1(rs1),
    .data0(data0), .data1(data1), .ack(ack), .busy(busy),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_data(lcd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, o, e);
    end
  endtask

  function automatic logic [15:0] obs();
    return {2'b00, busy, lcd_en, ack, lcd_rs, lcd_data, lcd_rw};
  endfunction

  function automatic int exec_len(input bit rs, input bit [7:0] d);
    return (!rs && d >= 8'h01 && d <= 8'h03) ? TXL : TX;
  endfunction

  // Expected pins k cycles after the grant edge of a write by requester w.
  function automatic logic [15:0] txn_exp(input int k, input int w, input bit rs,
                                          input bit [7:0] d, input int ne);
    bit       en;
    bit [1:0] a;
    en = (k >= TS) && (k < TS + TE);
    a  = (k == TS + TE + ne) ? ((w == 1) ? 2'b10 : 2'b01) : 2'b00;
    return {2'b00, 1'b1, en, a, rs, d, 1'b0};
  endfunction

  function automatic int pick();
    if (pend[0] && pend[1]) begin
`ifdef LCD_ARB_ROUND_ROBIN_EN
      return 1 - last_w;
`else
      return 0;
`endif
    end
    return pend[0] ? 0 : 1;
  endfunction

  task automatic drive();
    req   = {pend[1], pend[0]};
    rs0   = prs[0];
    rs1   = prs[1];
    data0 = pdat[0];
    data1 = pdat[1];
  endtask

  task automatic new_req(input int i);
    pend[i] = 1'b1;
    prs[i]  = 1'($urandom_range(0, 1));
    pdat[i] = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom);
  endtask

  task automatic idle_chk(input string tag);
    chk(tag, {12'h000, busy, lcd_en, ack}, 16'h0000);
  endtask

  // Called in the first power-up cycle; ends in the last one.
  task automatic powerup_chk();
    for (int k = 0; k < TP; k++) begin
      if (k > 0) step();
      chk($sformatf("powerup k%0d", k), {12'h000, busy, lcd_en, ack}, 16'h0008);
    end
  endtask

  // Called in an IDLE cycle with requests driven; ends in the DONE cycle.
  task automatic do_txn(input bit allow_drop, output int w);
    int ne;
    w      = pick();
    last_w = w;
    step();
    if (allow_drop && $urandom_range(0, 3) == 0) req[w] = 1'b0;
    ne = exec_len(prs[w], pdat[w]);
    for (int k = 0; k <= TS + TE + ne; k++) begin
      if (k > 0) step();
      chk($sformatf("txn w%0d d%02h k%0d", w, pdat[w], k), obs(),
          txn_exp(k, w, prs[w], pdat[w], ne));
    end
    pend[w] = 1'b0;
  endtask

  initial begin
    int       w;
    int       ne;
    bit       c_rs  [3];
    bit [7:0] c_dat [3];
    c_rs[0] = 1'b0; c_dat[0] = 8'h01;
    c_rs[1] = 1'b1; c_dat[1] = 8'h01;
    c_rs[2] = 1'b0; c_dat[2] = 8'h38;

    reset = 1'b0;
    req = 2'b00; rs0 = 1'b0; rs1 = 1'b0; data0 = 8'h00; data1 = 8'h00;
    pend[0] = 1'b0; pend[1] = 1'b0;
    prs[0] = 1'b0; prs[1] = 1'b0; pdat[0] = 8'h00; pdat[1] = 8'h00;
    last_w = 1;

    for (int k = 0; k < 3; k++) begin
      step();
      chk("reset", obs(), 16'h2000);
    end

    // Request held from the first cycle after reset; ignored until power-up elapses.
    pend[0] = 1'b1; prs[0] = 1'b1; pdat[0] = 8'h41;
    drive();
    reset = 1'b1;
    powerup_chk();
    step();
    idle_chk("first_idle");
    do_txn(1'b0, w);

    // Long vs normal execution waits.
    for (int i = 0; i < 3; i++) begin
      pend[0] = 1'b1; prs[0] = c_rs[i]; pdat[0] = c_dat[i];
      drive();
      step();
      idle_chk("exec_idle");
      do_txn(1'b0, w);
    end

    // Requester 1 raises req while ack[0] is high: no grant in DONE, granted at next IDLE edge.
    pend[1] = 1'b1; prs[1] = 1'b1; pdat[1] = 8'h5A;
    drive();
    step();
    idle_chk("no_grant_in_done");
    do_txn(1'b0, w);

    // Both requesters held continuously for four grants.
    new_req(0);
    new_req(1);
    for (int i = 0; i < 4; i++) begin
      drive();
      step();
      idle_chk("both_idle");
      do_txn(1'b0, w);
      new_req(w);
    end

    // Random traffic; requests may appear during DONE and req may drop after grant.
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < 2; i++)
        if (!pend[i] && $urandom_range(0, 1) == 1) new_req(i);
      drive();
      step();
      idle_chk("rnd_idle");
      if (!pend[0] && !pend[1]) begin
        step();
        idle_chk("rnd_quiet");
        new_req(int'($urandom_range(0, 1)));
        drive();
      end
      do_txn(1'b1, w);
    end

    // Reset during the second strobe cycle aborts the write and restarts power-up.
    if (!pend[0] && !pend[1]) new_req(0);
    drive();
    step();
    idle_chk("pre_rst_idle");
    w = pick();
    step();
    ne = exec_len(prs[w], pdat[w]);
    for (int k = 0; k <= TS + 1; k++) begin
      if (k > 0) step();
      chk($sformatf("pre_rst k%0d", k), obs(), txn_exp(k, w, prs[w], pdat[w], ne));
    end
    reset = 1'b0;
    step();
    chk("rst_mid_strobe", obs(), 16'h2000);
    reset = 1'b1;
    last_w = 1;
    powerup_chk();
    step();
    idle_chk("post_rst_idle");
    do_txn(1'b0, w);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
